// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - single-port VRAM arbiter: GPU reads win, CPU writes posted and committed in the writable window
module vram_write_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_12_5875,
    input  logic                          rst_n,
    input  logic                          writable_i,
    input  logic                          gpu_req_i,
    input  logic [ADDR_W-1:0]             gpu_addr_i,
    output logic                          gpu_rvalid_o,
    output logic [DATA_W-1:0]             gpu_rdata_o,
    input  logic                          cpu_wr_valid_i,
    output logic                          cpu_wr_ready_o,
    input  logic [ADDR_W-1:0]             cpu_wr_addr_i,
    input  logic [DATA_W-1:0]             cpu_wr_data_i,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o,
    output logic                          late_o,
    input  logic                          late_clr_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        LOCKED = 1'b0,
        OPEN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              full;
    logic              push;
    logic              pop;

    // Ready reflects registered occupancy only, so a same-cycle pop never raises it.
    assign full           = (count == CNT_W'(FIFO_DEPTH));
    assign cpu_wr_ready_o = rst_n && !full;
    assign push           = cpu_wr_valid_i && cpu_wr_ready_o;
    // Commit needs both the registered window and the live flag so nothing lands after close.
    assign pop            = rst_n && !gpu_req_i && (state == OPEN) && writable_i && (count != '0);
    assign pending_o      = count;
    assign gpu_rdata_o    = mem_rdata_i;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // VRAM port mux: GPU read first, then FIFO head commit, else idle showing the head.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = fifo_addr[rd_ptr];
        mem_wdata_o = fifo_data[rd_ptr];
        if (rst_n && gpu_req_i) begin
            mem_en_o   = 1'b1;
            mem_addr_o = gpu_addr_i;
        end else if (pop) begin
            mem_en_o = 1'b1;
            mem_we_o = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every use.
    always_ff @(posedge clk_12_5875) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr_i;
            fifo_data[wr_ptr] <= cpu_wr_data_i;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk_12_5875) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // Window state, read-valid pipeline and sticky late flag (set beats clear).
    always_ff @(posedge clk_12_5875) begin
        if (!rst_n) begin
            state        <= LOCKED;
            gpu_rvalid_o <= 1'b0;
            late_o       <= 1'b0;
        end else begin
            gpu_rvalid_o <= gpu_req_i;
            if ((state == OPEN) && !writable_i && (count_next != '0)) begin
                late_o <= 1'b1;
            end else if (late_clr_i) begin
                late_o <= 1'b0;
            end
            case (state)
                LOCKED:  if (writable_i)  state <= OPEN;
                OPEN:    if (!writable_i) state <= LOCKED;
                default: state <= LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - randomized and directed self-checking bench for vram_write_arbiter
module tb_vram_write_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk_12_5875 = 1'b0;
    logic              rst_n;
    logic              writable_i;
    logic              gpu_req_i;
    logic [ADDR_W-1:0] gpu_addr_i;
    logic              gpu_rvalid_o;
    logic [DATA_W-1:0] gpu_rdata_o;
    logic              cpu_wr_valid_i;
    logic              cpu_wr_ready_o;
    logic [ADDR_W-1:0] cpu_wr_addr_i;
    logic [DATA_W-1:0] cpu_wr_data_i;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [3:0]        pending_o;
    logic              late_o;
    logic              late_clr_i;

    vram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_12_5875    (clk_12_5875),
        .rst_n          (rst_n),
        .writable_i     (writable_i),
        .gpu_req_i      (gpu_req_i),
        .gpu_addr_i     (gpu_addr_i),
        .gpu_rvalid_o   (gpu_rvalid_o),
        .gpu_rdata_o    (gpu_rdata_o),
        .cpu_wr_valid_i (cpu_wr_valid_i),
        .cpu_wr_ready_o (cpu_wr_ready_o),
        .cpu_wr_addr_i  (cpu_wr_addr_i),
        .cpu_wr_data_i  (cpu_wr_data_i),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .pending_o      (pending_o),
        .late_o         (late_o),
        .late_clr_i     (late_clr_i)
    );

    always #5 clk_12_5875 = ~clk_12_5875;

    int n_chk = 0;
    int n_err = 0;
    int commits = 0;

    // Reference: posted writes as a queue of {addr,data}, window seen last cycle, late flag.
    logic [ADDR_W+DATA_W-1:0] q[$];
    bit                       win_prev = 0;
    bit                       m_late = 0;
    bit                       m_rvalid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs mid-cycle, then advance the model at the clock edge.
    task automatic step();
        bit exp_ready;
        bit do_commit;
        bit do_push;
        logic [ADDR_W+DATA_W-1:0] ent;
        @(negedge clk_12_5875);
        #1;
        exp_ready = rst_n && (q.size() < DEPTH);
        do_commit = rst_n && !gpu_req_i && win_prev && writable_i && (q.size() > 0);
        do_push   = cpu_wr_valid_i && exp_ready;
        check("ready", cpu_wr_ready_o, exp_ready);
        check("pending", pending_o, q.size());
        check("late", late_o, m_late);
        check("rvalid", gpu_rvalid_o, m_rvalid);
        if (m_rvalid) check("rdata", gpu_rdata_o, mem_rdata_i);
        if (!rst_n) begin
            check("en_rst", mem_en_o, 0);
        end else if (gpu_req_i) begin
            check("rd_en", mem_en_o, 1);
            check("rd_we", mem_we_o, 0);
            check("rd_addr", mem_addr_o, gpu_addr_i);
        end else if (do_commit) begin
            ent = q[0];
            check("wr_en", mem_en_o, 1);
            check("wr_we", mem_we_o, 1);
            check("wr_addr", mem_addr_o, ent[ADDR_W+DATA_W-1:DATA_W]);
            check("wr_data", mem_wdata_o, ent[DATA_W-1:0]);
        end else begin
            check("idle_en", mem_en_o, 0);
        end
        if (mem_en_o && mem_we_o) commits++;
        @(posedge clk_12_5875);
        if (!rst_n) begin
            q.delete();
            win_prev = 0;
            m_late   = 0;
            m_rvalid = 0;
        end else begin
            if (do_commit) void'(q.pop_front());
            if (do_push) q.push_back({cpu_wr_addr_i, cpu_wr_data_i});
            if (win_prev && !writable_i && q.size() > 0) m_late = 1;
            else if (late_clr_i) m_late = 0;
            win_prev = writable_i;
            m_rvalid = gpu_req_i;
        end
        #1;
        mem_rdata_i = DATA_W'($urandom);
    endtask

    task automatic idle_inputs();
        gpu_req_i      = 0;
        cpu_wr_valid_i = 0;
        late_clr_i     = 0;
    endtask

    task automatic post(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_wr_valid_i = 1;
        cpu_wr_addr_i  = a;
        cpu_wr_data_i  = d;
        step();
        cpu_wr_valid_i = 0;
    endtask

    initial begin
        rst_n = 0; writable_i = 0; gpu_req_i = 0; gpu_addr_i = '0;
        cpu_wr_valid_i = 1; cpu_wr_addr_i = '0; cpu_wr_data_i = '0;
        mem_rdata_i = '0; late_clr_i = 0;

        // Reset held 3 cycles with a write offered.
        repeat (3) step();
        check("rst_pending", pending_o, 0);
        rst_n = 1;
        idle_inputs();
        step();

        // Three posted writes while locked, then open the window.
        for (int i = 0; i < 3; i++) post(ADDR_W'(12'h011 + i), DATA_W'(8'hAA + 8'h11 * i));
        check("posted3", pending_o, 3);
        commits = 0;
        writable_i = 1;
        repeat (5) step();
        check("commits3", commits, 3);
        check("drained", pending_o, 0);

        // Two pending, GPU reads on alternate cycles.
        writable_i = 0;
        step();
        post(12'h100, 8'h01);
        post(12'h100, 8'h02);
        writable_i = 1;
        for (int i = 0; i < 8; i++) begin
            gpu_req_i  = (i % 2 == 0);
            gpu_addr_i = ADDR_W'($urandom);
            step();
        end
        gpu_req_i = 0;

        // Fill all entries locked; 9th stays offered until space appears.
        writable_i = 0;
        step();
        for (int i = 0; i < DEPTH; i++) post(ADDR_W'(12'h200 + i), DATA_W'(i));
        check("full_ready", cpu_wr_ready_o, 0);
        cpu_wr_valid_i = 1; cpu_wr_addr_i = 12'h2FF; cpu_wr_data_i = 8'h99;
        step();
        writable_i = 1;
        repeat (4) step();
        cpu_wr_valid_i = 0;
        repeat (12) step();

        // Window fully consumed by GPU reads, then closed with writes pending.
        writable_i = 0;
        step();
        for (int i = 0; i < 5; i++) post(ADDR_W'(12'h300 + i), DATA_W'(8'h50 + i));
        commits = 0;
        writable_i = 1; gpu_req_i = 1;
        repeat (3) step();
        writable_i = 0; gpu_req_i = 0;
        step();
        step();
        check("late_commits", commits, 0);
        check("late_set", late_o, 1);
        check("late_pend", pending_o, 5);
        late_clr_i = 1;
        step();
        late_clr_i = 0;
        step();
        check("late_clr", late_o, 0);

        // Reset while draining four entries.
        writable_i = 1;
        step();
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        commits = 0;
        repeat (4) step();
        check("rst_drain_pend", pending_o, 0);
        check("rst_drain_commits", commits, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) writable_i = ~writable_i;
            rst_n          = ($urandom_range(0, 299) != 0);
            gpu_req_i      = ($urandom_range(0, 2) == 0);
            gpu_addr_i     = ADDR_W'($urandom);
            cpu_wr_valid_i = ($urandom_range(0, 1) == 0);
            cpu_wr_addr_i  = ADDR_W'($urandom_range(0, 7));
            cpu_wr_data_i  = DATA_W'($urandom);
            late_clr_i     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
